// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared port ids, default widths and the read-pipe stage type
package dmem_arb_pkg;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    localparam int DEF_ADDR_W    = 7;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_MEM_LAT   = 1;
    localparam int DEF_MAX_BURST = 4;

    typedef struct packed {
        logic valid;
        logic port;
    } rdStage_t;

endpackage

// File: rtl/dmem_rd_tracker.sv
// dmem_rd_tracker: MEM_LAT-deep {valid, port} shift pipe turning issued reads into per-port rvalid
module dmem_rd_tracker
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue,
    input  logic       issuePort,
    output logic [1:0] rvalid
);

    rdStage_t pipe [MEM_LAT];
    rdStage_t tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: issue, port: issuePort};
            for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail      = pipe[MEM_LAT-1];
    assign rvalid[0] = tail.valid && (tail.port == PORT_CPU);
    assign rvalid[1] = tail.valid && (tail.port == PORT_HOST);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with bounded burst lock sharing one data memory port
// between the CPU (port 0) and the host loader (port 1), routing read data back by port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_LAT   = DEF_MEM_LAT,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [15:0]       p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [15:0]       p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    logic       last;
    logic [3:0] burstCnt;
    logic       anyReq;
    logic       lockHeld;
    logic       winner;
    logic [1:0] rvalid;
    logic       unusedAddr;

    // A zero count means the previous cycle was idle, so a tie falls back to plain round-robin.
    always_comb begin
        anyReq    = rst & (p0_req | p1_req);
        lockHeld  = (burstCnt != 4'd0) && (burstCnt < 4'(MAX_BURST));
        winner    = (p0_req && p1_req) ? (lockHeld ? last : ~last) : p1_req;
        p0_gnt    = anyReq & (winner == PORT_CPU);
        p1_gnt    = anyReq & (winner == PORT_HOST);
        mem_en    = anyReq;
        mem_we    = anyReq & (winner ? p1_we : p0_we);
        mem_addr  = anyReq ? (winner ? p1_addr[ADDR_W-1:0] : p0_addr[ADDR_W-1:0]) : '0;
        mem_wdata = anyReq ? (winner ? p1_wdata : p0_wdata) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last     <= PORT_HOST;
            burstCnt <= '0;
        end else if (anyReq) begin
            if (winner == last) begin
                burstCnt <= (burstCnt < 4'(MAX_BURST)) ? burstCnt + 4'd1 : burstCnt;
            end else begin
                last     <= winner;
                burstCnt <= 4'd1;
            end
        end else begin
            burstCnt <= '0;
        end
    end

    dmem_rd_tracker #(
        .MEM_LAT(MEM_LAT)
    ) rdTracker (
        .clk      (clk),
        .rst      (rst),
        .issue    (anyReq & ~mem_we),
        .issuePort(winner),
        .rvalid   (rvalid)
    );

    assign p0_rvalid  = rst & rvalid[0];
    assign p1_rvalid  = rst & rvalid[1];
    assign p0_rdata   = mem_rdata;
    assign p1_rdata   = mem_rdata;
    assign owner      = last;
    assign unusedAddr = ^{p0_addr[15:ADDR_W], p1_addr[15:ADDR_W]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: three arbiters (MEM_LAT 1..3) on shared stimulus, each with its own memory,
// checked by directed scenarios and a randomized run against a run-length reference model.
module tb_dmem_arbiter;

    localparam int MAX_BURST = 4;
    localparam int NCYC      = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0Req = 1'b0, p0We = 1'b0, p1Req = 1'b0, p1We = 1'b0;
    logic [15:0] p0Addr = '0, p1Addr = '0, p0Wdata = '0, p1Wdata = '0;
    logic [2:0]  p0Gnt, p1Gnt, p0Rv, p1Rv, memEn, memWe, owner;
    logic [6:0]  memAddr [3];
    logic [15:0] memWdata [3], memRdata [3], p0Rd [3], p1Rd [3];
    logic [15:0] refMem [128];
    logic        hRead [1024];
    logic        hPort [1024];
    logic [15:0] hData [1024];
    int          passCnt = 0, totalCnt = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] initVal(int i);
        return (i == 5) ? 16'hBEEF : 16'(i * 37 + 16'h1000);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lat
        logic [15:0] mem [128];
        logic [15:0] rp [g+1];
        dmem_arbiter #(.MEM_LAT(g + 1), .MAX_BURST(MAX_BURST)) dut (
            .clk(clk), .rst(rst),
            .p0_req(p0Req), .p0_we(p0We), .p0_addr(p0Addr), .p0_wdata(p0Wdata),
            .p0_gnt(p0Gnt[g]), .p0_rvalid(p0Rv[g]), .p0_rdata(p0Rd[g]),
            .p1_req(p1Req), .p1_we(p1We), .p1_addr(p1Addr), .p1_wdata(p1Wdata),
            .p1_gnt(p1Gnt[g]), .p1_rvalid(p1Rv[g]), .p1_rdata(p1Rd[g]),
            .mem_en(memEn[g]), .mem_we(memWe[g]), .mem_addr(memAddr[g]),
            .mem_wdata(memWdata[g]), .mem_rdata(memRdata[g]), .owner(owner[g])
        );
        initial for (int i = 0; i < 128; i++) mem[i] <= initVal(i);
        always @(posedge clk) begin
            if (memEn[g] && memWe[g]) mem[memAddr[g]] <= memWdata[g];
            rp[0] <= mem[memAddr[g]];
            for (int i = 1; i <= g; i++) rp[i] <= rp[i-1];
        end
        assign memRdata[g] = rp[g];
    end

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst = 1'b0;
        {p0Req, p1Req, p0We, p1We} = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        p0Req = 1'b1;
        p1Req = 1'b1;
        @(negedge clk);
        totalCnt++; if ({p0Gnt, p1Gnt} !== 6'b0) $display("FAIL reset_gnt got %b want 0", {p0Gnt, p1Gnt}); else passCnt++;
        totalCnt++; if (memEn !== 3'b0) $display("FAIL reset_mem_en got %b want 000", memEn); else passCnt++;
        totalCnt++; if (owner !== 3'b111) $display("FAIL reset_owner got %b want 111", owner); else passCnt++;
        totalCnt++; if ({p0Rv, p1Rv} !== 6'b0) $display("FAIL reset_rvalid got %b want 0", {p0Rv, p1Rv}); else passCnt++;
    endtask

    task automatic test_single_read;
        doReset;
        p0Req = 1'b1;
        p0Addr = 16'h0005;
        @(negedge clk);
        totalCnt++; if ({p1Gnt[0], p0Gnt[0]} !== 2'b01) $display("FAIL single_gnt got %b want 01", {p1Gnt[0], p0Gnt[0]}); else passCnt++;
        totalCnt++; if ({memEn[0], memWe[0]} !== 2'b10) $display("FAIL single_en_we got %b want 10", {memEn[0], memWe[0]}); else passCnt++;
        totalCnt++; if (memAddr[0] !== 7'd5) $display("FAIL single_addr got %h want 05", memAddr[0]); else passCnt++;
        nextCycle;
        p0Req = 1'b0;
        @(negedge clk);
        totalCnt++; if ({p1Rv[0], p0Rv[0]} !== 2'b01) $display("FAIL single_rvalid got %b want 01", {p1Rv[0], p0Rv[0]}); else passCnt++;
        totalCnt++; if (p0Rd[0] !== 16'hBEEF) $display("FAIL single_rdata got %h want beef", p0Rd[0]); else passCnt++;
        nextCycle;
        @(negedge clk);
        totalCnt++; if ({p1Rv[0], p0Rv[0]} !== 2'b00) $display("FAIL single_rvalid_once got %b want 00", {p1Rv[0], p0Rv[0]}); else passCnt++;
    endtask

    task automatic test_burst;
        logic e, pv;
        doReset;
        {p0Req, p1Req} = 2'b11;
        p0Addr = 16'd10;
        p1Addr = 16'd20;
        for (int i = 0; i < 13; i++) begin
            if (i == 12) {p0Req, p1Req} = 2'b00;
            @(negedge clk);
            if (i < 12) begin
                e = 1'((i / 4) % 2);
                totalCnt++; if ({p1Gnt[0], p0Gnt[0]} !== {e, ~e}) $display("FAIL burst_gnt[%0d] got %b want %b", i, {p1Gnt[0], p0Gnt[0]}, {e, ~e}); else passCnt++;
            end
            if (i > 0) begin
                pv = 1'(((i - 1) / 4) % 2);
                totalCnt++; if ({p1Rv[0], p0Rv[0]} !== {pv, ~pv}) $display("FAIL burst_rvalid[%0d] got %b want %b", i, {p1Rv[0], p0Rv[0]}, {pv, ~pv}); else passCnt++;
                totalCnt++; if ((pv ? p1Rd[0] : p0Rd[0]) !== (pv ? refMem[20] : refMem[10])) $display("FAIL burst_rdata[%0d] got %h want %h", i, pv ? p1Rd[0] : p0Rd[0], pv ? refMem[20] : refMem[10]); else passCnt++;
            end
            nextCycle;
        end
    endtask

    task automatic test_write_trunc;
        doReset;
        p1Req = 1'b1; p1We = 1'b1; p1Addr = 16'h0087; p1Wdata = 16'h1234;
        @(negedge clk);
        totalCnt++; if ({p1Gnt[0], memWe[0]} !== 2'b11) $display("FAIL wr_gnt_we got %b want 11", {p1Gnt[0], memWe[0]}); else passCnt++;
        totalCnt++; if (memAddr[0] !== 7'h07) $display("FAIL wr_addr got %h want 07", memAddr[0]); else passCnt++;
        totalCnt++; if (memWdata[0] !== 16'h1234) $display("FAIL wr_wdata got %h want 1234", memWdata[0]); else passCnt++;
        refMem[7] = 16'h1234;
        nextCycle;
        {p1Req, p1We} = 2'b00;
        p0Req = 1'b1; p0Addr = 16'h0007;
        @(negedge clk);
        totalCnt++; if (p0Gnt[0] !== 1'b1) $display("FAIL raw_gnt got %b want 1", p0Gnt[0]); else passCnt++;
        totalCnt++; if ({p1Rv[0], p0Rv[0]} !== 2'b00) $display("FAIL wr_no_rvalid got %b want 00", {p1Rv[0], p0Rv[0]}); else passCnt++;
        nextCycle;
        p0Req = 1'b0;
        @(negedge clk);
        totalCnt++; if ({p1Rv[0], p0Rv[0]} !== 2'b01) $display("FAIL raw_rvalid got %b want 01", {p1Rv[0], p0Rv[0]}); else passCnt++;
        totalCnt++; if (p0Rd[0] !== 16'h1234) $display("FAIL raw_rdata got %h want 1234", p0Rd[0]); else passCnt++;
    endtask

    task automatic test_reset_flight;
        doReset;
        p0Req = 1'b1; p0Addr = 16'd9;
        @(negedge clk);
        totalCnt++; if (p0Gnt[2] !== 1'b1) $display("FAIL flight_gnt got %b want 1", p0Gnt[2]); else passCnt++;
        nextCycle;
        p0Req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        totalCnt++; if (p0Rv[2] !== 1'b0) $display("FAIL flight_rvalid_in_reset got %b want 0", p0Rv[2]); else passCnt++;
        nextCycle;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            totalCnt++; if (p0Rv[2] !== 1'b0) $display("FAIL flight_rvalid[%0d] got %b want 0", i, p0Rv[2]); else passCnt++;
            nextCycle;
        end
        {p0Req, p1Req} = 2'b11;
        @(negedge clk);
        totalCnt++; if ({p1Gnt[2], p0Gnt[2]} !== 2'b01) $display("FAIL flight_first_tie got %b want 01", {p1Gnt[2], p0Gnt[2]}); else passCnt++;
        nextCycle;
        {p0Req, p1Req} = 2'b00;
    endtask

    task automatic test_host_streak;
        doReset;
        p1Req = 1'b1; p1Addr = 16'd30;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            totalCnt++; if ({p1Gnt[0], p0Gnt[0]} !== 2'b10) $display("FAIL streak_gnt[%0d] got %b want 10", i, {p1Gnt[0], p0Gnt[0]}); else passCnt++;
            nextCycle;
        end
        p0Req = 1'b1; p0Addr = 16'd31;
        @(negedge clk);
        totalCnt++; if ({p1Gnt[0], p0Gnt[0]} !== 2'b01) $display("FAIL streak_join got %b want 01", {p1Gnt[0], p0Gnt[0]}); else passCnt++;
        nextCycle;
        @(negedge clk);
        totalCnt++; if ({p1Gnt[0], p0Gnt[0]} !== 2'b01) $display("FAIL streak_next got %b want 01", {p1Gnt[0], p0Gnt[0]}); else passCnt++;
        nextCycle;
        {p0Req, p1Req} = 2'b00;
        nextCycle;
        nextCycle;
    endtask

    task automatic test_alternating;
        int rvPort [6] = '{-1, -1, 0, 1, 0, -1};
        logic [15:0] rvData [6];
        rvData = '{16'h0, 16'h0, refMem[40], refMem[41], refMem[42], 16'h0};
        doReset;
        for (int t = 0; t < 6; t++) begin
            p0Req = (t == 0) || (t == 2);
            p1Req = (t == 1);
            p0Addr = (t == 0) ? 16'd40 : 16'd42;
            p1Addr = 16'd41;
            @(negedge clk);
            if (t < 3) begin
                totalCnt++; if ({p1Gnt[1], p0Gnt[1]} !== {p1Req, p0Req}) $display("FAIL alt_gnt[%0d] got %b want %b", t, {p1Gnt[1], p0Gnt[1]}, {p1Req, p0Req}); else passCnt++;
            end
            totalCnt++; if ({p1Rv[1], p0Rv[1]} !== {rvPort[t] == 1, rvPort[t] == 0}) $display("FAIL alt_rvalid[%0d] got %b want %b", t, {p1Rv[1], p0Rv[1]}, {rvPort[t] == 1, rvPort[t] == 0}); else passCnt++;
            if (rvPort[t] >= 0) begin
                totalCnt++; if ((rvPort[t] == 1 ? p1Rd[1] : p0Rd[1]) !== rvData[t]) $display("FAIL alt_rdata[%0d] got %h want %h", t, rvPort[t] == 1 ? p1Rd[1] : p0Rd[1], rvData[t]); else passCnt++;
            end
            nextCycle;
        end
    endtask

    task automatic test_random;
        logic mLast, w, any, wWe, eP0, eP1;
        int mRun, k;
        logic [6:0] wAddr;
        logic [15:0] wData, got, want;
        doReset;
        mLast = 1'b1;
        mRun = 0;
        for (int cyc = 0; cyc < NCYC + 4; cyc++) begin
            p0Req = (cyc < NCYC) && ($urandom_range(0, 3) != 0);
            p1Req = (cyc < NCYC) && ($urandom_range(0, 3) != 0);
            p0We = ($urandom_range(0, 2) == 0);
            p1We = ($urandom_range(0, 2) == 0);
            p0Addr = 16'(($urandom & 32'hFF80) | $urandom_range(0, 15));
            p1Addr = 16'(($urandom & 32'hFF80) | $urandom_range(0, 15));
            p0Wdata = 16'($urandom);
            p1Wdata = 16'($urandom);
            @(negedge clk);
            any = p0Req || p1Req;
            w = (p0Req && p1Req) ? ((mRun >= 1 && mRun < MAX_BURST) ? mLast : ~mLast) : p1Req;
            wWe = w ? p1We : p0We;
            wAddr = w ? p1Addr[6:0] : p0Addr[6:0];
            wData = w ? p1Wdata : p0Wdata;
            for (int g = 0; g < 3; g++) begin
                totalCnt++; if ({p1Gnt[g], p0Gnt[g]} !== (any ? (w ? 2'b10 : 2'b01) : 2'b00)) $display("FAIL rnd_gnt[%0d] lat%0d got %b", cyc, g + 1, {p1Gnt[g], p0Gnt[g]}); else passCnt++;
                totalCnt++; if (owner[g] !== mLast) $display("FAIL rnd_owner[%0d] lat%0d got %b want %b", cyc, g + 1, owner[g], mLast); else passCnt++;
                totalCnt++; if ({memEn[g], memWe[g]} !== {any, any && wWe}) $display("FAIL rnd_en_we[%0d] lat%0d got %b want %b", cyc, g + 1, {memEn[g], memWe[g]}, {any, any && wWe}); else passCnt++;
                if (any) begin
                    totalCnt++; if (memAddr[g] !== wAddr) $display("FAIL rnd_addr[%0d] lat%0d got %h want %h", cyc, g + 1, memAddr[g], wAddr); else passCnt++;
                end
                if (any && wWe) begin
                    totalCnt++; if (memWdata[g] !== wData) $display("FAIL rnd_wdata[%0d] lat%0d got %h want %h", cyc, g + 1, memWdata[g], wData); else passCnt++;
                end
                k = cyc - g - 1;
                eP0 = (k >= 0) && hRead[k] && !hPort[k];
                eP1 = (k >= 0) && hRead[k] && hPort[k];
                totalCnt++; if ({p1Rv[g], p0Rv[g]} !== {eP1, eP0}) $display("FAIL rnd_rvalid[%0d] lat%0d got %b want %b", cyc, g + 1, {p1Rv[g], p0Rv[g]}, {eP1, eP0}); else passCnt++;
                if (eP0 || eP1) begin
                    got = eP1 ? p1Rd[g] : p0Rd[g];
                    want = hData[k];
                    totalCnt++; if (got !== want) $display("FAIL rnd_rdata[%0d] lat%0d got %h want %h", cyc, g + 1, got, want); else passCnt++;
                end
            end
            hRead[cyc] = any && !wWe;
            hPort[cyc] = w;
            hData[cyc] = refMem[wAddr];
            if (any && wWe) refMem[wAddr] = wData;
            if (!any) mRun = 0;
            else if (w == mLast) mRun++;
            else begin
                mLast = w;
                mRun = 1;
            end
            nextCycle;
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) refMem[i] = initVal(i);
        test_reset;
        test_single_read;
        test_burst;
        test_write_trunc;
        test_reset_flight;
        test_host_streak;
        test_alternating;
        test_random;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
